// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the iteration-counter width helper.
package mul_pkg;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_RUN  = 2'd1,
      MS_DONE = 2'd2
   } ms_state_e;

   // Counter must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : mul_pkg

// File: rtl/mul_row.sv
// One row of N partial-product/full-adder cells: so/co = si + (x & y) + ci.
// With MUL_SEQ_SIGNED_EN defined, sum[N] is the sign of the true (N+1)-bit result.
module mul_row #(
   parameter int N = 4
) (
   input  logic [N-1:0] si,
   input  logic [N-1:0] x,
   input  logic         y,
   input  logic         ci,
   output logic [N:0]   sum
);

   always_comb begin
      logic c;
      logic pp;
      // NOTE: blocking assignments are correct here; c ripples cell to cell
      // within one evaluation, which non-blocking would break.
      sum = '0;
      c   = ci;
      for (int i = 0; i < N; i++) begin
         pp     = x[i] & y;
         sum[i] = si[i] ^ pp ^ c;
         c      = (si[i] & pp) | (si[i] & c) | (pp & c);
      end
`ifdef MUL_SEQ_SIGNED_EN
      // Both row inputs are sign-extended by one bit, so the top bit is their XOR with the carry.
      sum[N] = si[N-1] ^ (x[N-1] & y) ^ c;
`else
      sum[N] = c;
`endif
   end

endmodule : mul_row

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, 2N-bit product
// after N steps. Define MUL_SEQ_SIGNED_EN for two's-complement operands.
module mul_seq
   import mul_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] p
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   ms_state_e      state_q, state_d;
   logic [N-1:0]   areg_q, areg_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] p_q, p_d;

   logic           last_step;
   logic [N-1:0]   row_x;
   logic           row_ci;
   logic [N:0]     row_sum;
   logic [2*N-1:0] acc_step;

   assign last_step = (cnt_q == CNT_LAST);

`ifdef MUL_SEQ_SIGNED_EN
   // The multiplier's sign bit carries weight -2^(N-1): subtract on the last step.
   assign row_x  = (last_step && acc_q[0]) ? ~areg_q : areg_q;
   assign row_ci = last_step & acc_q[0];
`else
   assign row_x  = areg_q;
   assign row_ci = 1'b0;
`endif

   mul_row #(.N(N)) u_row (
      .si  (acc_q[2*N-1:N]),
      .x   (row_x),
      .y   (acc_q[0]),
      .ci  (row_ci),
      .sum (row_sum)
   );

   assign acc_step = {row_sum, acc_q[N-1:1]};

   always_comb begin
      state_d = state_q;
      areg_d  = areg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      unique case (state_q)
         MS_IDLE, MS_DONE: begin
            if (start) begin
               areg_d  = a;
               acc_d   = {{N{1'b0}}, b};
               cnt_d   = '0;
               state_d = MS_RUN;
            end else begin
               state_d = MS_IDLE;
            end
         end
         MS_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
               p_d     = acc_step;
               state_d = MS_DONE;
            end
         end
         default: state_d = MS_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MS_IDLE;
         areg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         areg_q  <= areg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign busy = (state_q == MS_RUN);
   assign done = (state_q == MS_DONE);
   assign p    = p_q;

endmodule : mul_seq
